// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types for the DATA_MEMORY port arbiter.
//   - owner_e   : owner FSM state (IDLE, OWN0, OWN1)
//   - port_id_t : requester identifier (0 = core LSU, 1 = DMA/debug loader)
//   - NUM_PORTS : number of requesters sharing the memory
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    typedef logic port_id_t;

endpackage

// File: rtl/dmem_rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// dmem_rd_tag_pipe
//   Carries the issuing port id of each memory read alongside the memory's
//   read latency, so the returning data can be steered to the right port.
//   Ports:
//     clk, rst   clock, synchronous active-high clear (drops in-flight tags)
//     in_valid   a read strobe is on the memory pins this cycle
//     in_port    port that issued that read
//     out_valid  read data is on mem_rdata this cycle
//     out_port   port that owns that read data
// ---------------------------------------------------------------------------
module dmem_rd_tag_pipe
    import dmem_arb_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    input  port_id_t in_port,
    output logic     out_valid,
    output port_id_t out_port
);

    logic [RD_LATENCY-1:0] valid_q, valid_d;
    logic [RD_LATENCY-1:0] port_q,  port_d;

    // NOTE: every stage gets a value on every path through the block, so no
    // latch is inferred even though the shift is written as a loop.
    always_comb begin
        valid_d    = '0;
        port_d     = '0;
        valid_d[0] = in_valid;
        port_d[0]  = in_port;
        for (int i = 1; i < RD_LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            port_d[i]  = port_q[i-1];
        end
    end

    // NOTE: state is updated with non-blocking assignments so every stage
    // samples the previous stage's value from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            port_q  <= '0;
        end else begin
            valid_q <= valid_d;
            port_q  <= port_d;
        end
    end

    assign out_valid = valid_q[RD_LATENCY-1];
    assign out_port  = port_q[RD_LATENCY-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares DATA_MEMORY between port 0 (core LSU) and port 1 (DMA/debug
//   loader). One beat per cycle is granted (round-robin or fixed priority),
//   a requester may lock ownership across a burst, the winning command is
//   registered onto the memory pins and read data is routed back to the
//   port that issued it.
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     reqN_valid/we/lock/addr/wdata  request from port N
//     reqN_ready                   grant (combinational), beat taken on valid&&ready
//     respN_valid/rdata            read return for port N (rdata 0 when not valid)
//     mem_read/mem_write           registered strobes to DATA_MEMORY
//     rd_addr/wr_addr/data_in      registered address/data to DATA_MEMORY
//     mem_rdata                    DATA_MEMORY read data
// ---------------------------------------------------------------------------
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int RD_LATENCY = 1,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic              req0_lock,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic              req1_lock,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e            state_q,     state_d;
    port_id_t          last_q,      last_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
    logic [DATA_W-1:0] data_in_q,   data_in_d;
    port_id_t          cmd_port_q,  cmd_port_d;

    logic              acc0, acc1, any_acc;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              tag_valid;
    port_id_t          tag_port;

    // Grant. An owner gets ready even with no beat pending; in IDLE only a
    // valid requester is granted, so both readies can be low.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            OWN0: req0_ready = 1'b1;
            OWN1: req1_ready = 1'b1;
            default: begin
                if (FIXED_PRIO) begin
                    req0_ready = req0_valid;
                    req1_ready = req1_valid && !req0_valid;
                end else begin
                    // On a tie, the port that did not win last time goes.
                    req0_ready = req0_valid && (!req1_valid || last_q == 1'b1);
                    req1_ready = req1_valid && (!req0_valid || last_q == 1'b0);
                end
            end
        endcase
    end

    assign acc0    = req0_valid && req0_ready;
    assign acc1    = req1_valid && req1_ready;
    assign any_acc = acc0 || acc1;

    // Owner FSM and round-robin pointer.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (acc0) begin
            last_d = 1'b0;
        end else if (acc1) begin
            last_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (acc0 && req0_lock) begin
                    state_d = OWN0;
                end else if (acc1 && req1_lock) begin
                    state_d = OWN1;
                end
            end
            // The owner is always ready, so "accepted beat with lock low" and
            // "lock low while idle" both reduce to lock being low.
            OWN0: if (!req0_lock) state_d = IDLE;
            OWN1: if (!req1_lock) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command register. Grants are exclusive, so acc1 alone picks the source.
    assign sel_we    = acc1 ? req1_we    : req0_we;
    assign sel_addr  = acc1 ? req1_addr  : req0_addr;
    assign sel_wdata = acc1 ? req1_wdata : req0_wdata;

    always_comb begin
        mem_read_d  = any_acc && !sel_we;
        mem_write_d = any_acc && sel_we;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        data_in_d   = data_in_q;
        cmd_port_d  = acc1;
        if (mem_read_d) begin
            rd_addr_d = sel_addr;
        end
        if (mem_write_d) begin
            wr_addr_d = sel_addr;
            data_in_d = sel_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            data_in_q   <= '0;
            cmd_port_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            data_in_q   <= data_in_d;
            cmd_port_q  <= cmd_port_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign rd_addr   = rd_addr_q;
    assign wr_addr   = wr_addr_q;
    assign data_in   = data_in_q;

    // The tag enters alongside the registered read strobe and leaves when the
    // memory presents the data.
    dmem_rd_tag_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (mem_read_q),
        .in_port   (cmd_port_q),
        .out_valid (tag_valid),
        .out_port  (tag_port)
    );

    assign resp0_valid = tag_valid && (tag_port == 1'b0);
    assign resp1_valid = tag_valid && (tag_port == 1'b1);
    assign resp0_rdata = resp0_valid ? mem_rdata : '0;
    assign resp1_rdata = resp1_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Three arbiter instances share one set of request inputs:
//     dut_rr : RD_LATENCY=1, round-robin
//     dut_fp : RD_LATENCY=1, fixed priority
//     dut_l3 : RD_LATENCY=3, round-robin (random traffic vs. scoreboard)
//   Each memory model returns fill(addr) for locations never written.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_we, req0_lock;
    logic [9:0]  req0_addr;
    logic [63:0] req0_wdata;
    logic        req1_valid, req1_we, req1_lock;
    logic [9:0]  req1_addr;
    logic [63:0] req1_wdata;

    logic        a_req0_ready, a_req1_ready, a_resp0_valid, a_resp1_valid;
    logic [63:0] a_resp0_rdata, a_resp1_rdata, a_data_in, a_mem_rdata;
    logic        a_mem_read, a_mem_write;
    logic [9:0]  a_rd_addr, a_wr_addr;

    logic        f_req0_ready, f_req1_ready, f_resp0_valid, f_resp1_valid;
    logic [63:0] f_resp0_rdata, f_resp1_rdata, f_data_in, f_mem_rdata;
    logic        f_mem_read, f_mem_write;
    logic [9:0]  f_rd_addr, f_wr_addr;

    logic        c_req0_ready, c_req1_ready, c_resp0_valid, c_resp1_valid;
    logic [63:0] c_resp0_rdata, c_resp1_rdata, c_data_in, c_mem_rdata;
    logic        c_mem_read, c_mem_write;
    logic [9:0]  c_rd_addr, c_wr_addr;

    int n_vec  = 0;
    int n_miss = 0;

    function automatic logic [63:0] fill(input logic [9:0] a);
        return {16'hC0DE, 6'd0, a, 22'd0, a};
    endfunction

    dmem_port_arbiter #(.ADDR_W(10), .DATA_W(64), .RD_LATENCY(1), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(a_req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(a_req1_ready),
        .resp0_valid(a_resp0_valid), .resp0_rdata(a_resp0_rdata),
        .resp1_valid(a_resp1_valid), .resp1_rdata(a_resp1_rdata),
        .mem_read(a_mem_read), .mem_write(a_mem_write), .rd_addr(a_rd_addr),
        .wr_addr(a_wr_addr), .data_in(a_data_in), .mem_rdata(a_mem_rdata)
    );

    dmem_port_arbiter #(.ADDR_W(10), .DATA_W(64), .RD_LATENCY(1), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(f_req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(f_req1_ready),
        .resp0_valid(f_resp0_valid), .resp0_rdata(f_resp0_rdata),
        .resp1_valid(f_resp1_valid), .resp1_rdata(f_resp1_rdata),
        .mem_read(f_mem_read), .mem_write(f_mem_write), .rd_addr(f_rd_addr),
        .wr_addr(f_wr_addr), .data_in(f_data_in), .mem_rdata(f_mem_rdata)
    );

    dmem_port_arbiter #(.ADDR_W(10), .DATA_W(64), .RD_LATENCY(3), .FIXED_PRIO(1'b0)) dut_l3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(c_req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(c_req1_ready),
        .resp0_valid(c_resp0_valid), .resp0_rdata(c_resp0_rdata),
        .resp1_valid(c_resp1_valid), .resp1_rdata(c_resp1_rdata),
        .mem_read(c_mem_read), .mem_write(c_mem_write), .rd_addr(c_rd_addr),
        .wr_addr(c_wr_addr), .data_in(c_data_in), .mem_rdata(c_mem_rdata)
    );

    assign f_mem_rdata = '0;

    // Memory model, 1-cycle read latency.
    logic [63:0] a_mem [1024];
    bit          a_wr  [1024];
    logic [63:0] a_rdq = '0;
    always @(posedge clk) begin
        if (a_mem_write) begin
            a_mem[a_wr_addr] <= a_data_in;
            a_wr[a_wr_addr]  <= 1'b1;
        end
        if (a_mem_read) a_rdq <= a_wr[a_rd_addr] ? a_mem[a_rd_addr] : fill(a_rd_addr);
    end
    assign a_mem_rdata = a_rdq;

    // Memory model, 3-cycle read latency.
    logic [63:0] c_mem [1024];
    bit          c_wr  [1024];
    logic [63:0] c_p0 = '0, c_p1 = '0, c_p2 = '0;
    always @(posedge clk) begin
        if (c_mem_write) begin
            c_mem[c_wr_addr] <= c_data_in;
            c_wr[c_wr_addr]  <= 1'b1;
        end
        if (c_mem_read) c_p0 <= c_wr[c_rd_addr] ? c_mem[c_rd_addr] : fill(c_rd_addr);
        c_p1 <= c_p0;
        c_p2 <= c_p1;
    end
    assign c_mem_rdata = c_p2;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_we = 1'b0; req0_lock = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_lock = 1'b0; req1_addr = '0; req1_wdata = '0;
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        port;
        logic [63:0] data;
        int          due;
    } exp_t;

    logic [63:0] sb_mem [1024];
    exp_t        q[$];
    exp_t        e;
    logic        tb_last, e0, e1, sp;
    logic [9:0]  ea;

    initial begin
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 1024; i++) sb_mem[i] = fill(10'(i));

        // ---- reset state
        do_reset();
        #1;
        check("rst_mem_read",  a_mem_read,    0);
        check("rst_mem_write", a_mem_write,   0);
        check("rst_rd_addr",   a_rd_addr,     0);
        check("rst_wr_addr",   a_wr_addr,     0);
        check("rst_data_in",   a_data_in,     0);
        check("rst_resp_v",    {a_resp0_valid, a_resp1_valid}, 0);
        check("rst_rdata0",    a_resp0_rdata, 0);
        check("rst_ready",     {a_req0_ready, a_req1_ready}, 0);
        @(negedge clk);

        // ---- 1: port 0 write then read of 0x005
        req0_valid = 1; req0_we = 1; req0_addr = 10'h005; req0_wdata = 64'hDEADBEEF_00000001;
        #1; check("t1_rdy_wr", a_req0_ready, 1);
        @(negedge clk);
        req0_we = 0;
        #1;
        check("t1_rdy_rd",   a_req0_ready, 1);
        check("t1_mem_write", a_mem_write, 1);
        check("t1_mem_read0", a_mem_read,  0);
        check("t1_wr_addr",  a_wr_addr,    10'h005);
        check("t1_data_in",  a_data_in,    64'hDEADBEEF_00000001);
        check("t1_resp_early", {a_resp0_valid, a_resp1_valid}, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("t1_mem_read",  a_mem_read,  1);
        check("t1_mem_write0", a_mem_write, 0);
        check("t1_rd_addr",   a_rd_addr,   10'h005);
        check("t1_resp_early2", {a_resp0_valid, a_resp1_valid}, 0);
        @(negedge clk);
        #1;
        check("t1_resp0_v",  a_resp0_valid, 1);
        check("t1_resp0_d",  a_resp0_rdata, 64'hDEADBEEF_00000001);
        check("t1_resp1_v",  a_resp1_valid, 0);
        check("t1_resp1_d",  a_resp1_rdata, 0);
        @(negedge clk);
        #1;
        check("t1_resp0_pulse", a_resp0_valid, 0);
        check("t1_resp0_zero",  a_resp0_rdata, 0);
        @(negedge clk);

        // ---- 2: both ports read every cycle, round-robin from port 0
        do_reset();
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                req0_valid = 1; req0_we = 0; req0_addr = 10'(10'h010 + k);
                req1_valid = 1; req1_we = 0; req1_addr = 10'(10'h020 + k);
            end else begin
                idle_inputs();
            end
            #1;
            if (k < 6) begin
                check("t2_rdy0", a_req0_ready, (k % 2 == 0));
                check("t2_rdy1", a_req1_ready, (k % 2 == 1));
            end
            if (k >= 1 && k <= 6) check("t2_mem_read", a_mem_read, 1);
            if (k >= 2) begin
                ea = ((k - 2) % 2 == 0) ? 10'(10'h010 + k - 2) : 10'(10'h020 + k - 2);
                check("t2_resp0_v", a_resp0_valid, ((k - 2) % 2 == 0));
                check("t2_resp1_v", a_resp1_valid, ((k - 2) % 2 == 1));
                check("t2_rdata", ((k - 2) % 2 == 0) ? a_resp0_rdata : a_resp1_rdata, fill(ea));
            end
            @(negedge clk);
        end

        // ---- 3: port 1 locked write burst, port 0 locked out
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req1_valid = 1; req1_we = 1; req1_lock = (k < 3);
            req1_addr = 10'(10'h100 + k); req1_wdata = 64'h1111_0000_0000_0000 + 64'(k);
            req0_valid = (k > 0); req0_we = 0; req0_addr = 10'h030;
            #1;
            check("t3_rdy0_locked", a_req0_ready, 0);
            check("t3_rdy1_owner",  a_req1_ready, 1);
            if (k > 0) begin
                check("t3_mem_write", a_mem_write, 1);
                check("t3_wr_addr",   a_wr_addr,   10'(10'h100 + k - 1));
            end
            @(negedge clk);
        end
        req1_valid = 0; req1_lock = 0;
        #1;
        check("t3_rdy0_after", a_req0_ready, 1);
        check("t3_last_write", a_wr_addr,    10'h103);
        check("t3_last_data",  a_data_in,    64'h1111_0000_0000_0003);
        @(negedge clk);
        // lock held with no beat, then dropped while idle
        req1_valid = 1; req1_lock = 1; req1_we = 1; req1_addr = 10'h104;
        #1; check("t3b_rdy1_rr", a_req1_ready, 1); check("t3b_rdy0_rr", a_req0_ready, 0);
        @(negedge clk);
        req1_valid = 0;
        #1; check("t3b_hold_rdy0", a_req0_ready, 0); check("t3b_hold_rdy1", a_req1_ready, 1);
        @(negedge clk);
        req1_lock = 0;
        #1; check("t3b_drop_rdy0", a_req0_ready, 0);
        @(negedge clk);
        #1; check("t3b_free_rdy0", a_req0_ready, 1);
        @(negedge clk);

        // ---- 4: fixed priority, port 0 always wins
        do_reset();
        req0_valid = 1; req0_we = 0; req0_addr = 10'h011;
        req1_valid = 1; req1_we = 0; req1_addr = 10'h021;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("t4_fp_rdy0", f_req0_ready, 1);
            check("t4_fp_rdy1", f_req1_ready, 0);
            @(negedge clk);
        end
        req0_valid = 0;
        #1; check("t4_fp_only1", f_req1_ready, 1);
        @(negedge clk);

        // ---- 5: reset one cycle after a read is accepted
        do_reset();
        req0_valid = 1; req0_we = 0; req0_addr = 10'h012;
        #1; check("t5_rdy0", a_req0_ready, 1);
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t5_resp_v",  {a_resp0_valid, a_resp1_valid}, 0);
            check("t5_mem_rd",  a_mem_read, 0);
            check("t5_rd_addr", a_rd_addr,  0);
            check("t5_rdata0",  a_resp0_rdata, 0);
            @(negedge clk);
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        check("t5_next_rdy0", a_req0_ready, 1);
        check("t5_next_rdy1", a_req1_ready, 0);
        @(negedge clk);

        // ---- 6: random traffic, RD_LATENCY=3, against a scoreboard
        do_reset();
        tb_last = 1'b1;
        for (int cyc = 0; cyc < 1006; cyc++) begin
            if (cyc < 1000) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_we    = 1'($urandom_range(0, 1));
                req0_addr  = 10'(10'h040 + $urandom_range(0, 15));
                req0_wdata = {$urandom, $urandom};
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_we    = 1'($urandom_range(0, 1));
                req1_addr  = 10'(10'h040 + $urandom_range(0, 15));
                req1_wdata = {$urandom, $urandom};
            end else begin
                idle_inputs();
            end
            #1;
            e0 = req0_valid && (!req1_valid || tb_last == 1'b1);
            e1 = req1_valid && !e0;
            check("t6_rdy0", c_req0_ready, e0);
            check("t6_rdy1", c_req1_ready, e1);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("t6_resp0_v", c_resp0_valid, !e.port);
                check("t6_resp1_v", c_resp1_valid, e.port);
                check("t6_rdata", e.port ? c_resp1_rdata : c_resp0_rdata, e.data);
            end else begin
                check("t6_no_resp", {c_resp0_valid, c_resp1_valid}, 0);
            end
            if (e0 || e1) begin
                sp = e1;
                ea = sp ? req1_addr : req0_addr;
                if (sp ? req1_we : req0_we) begin
                    sb_mem[ea] = sp ? req1_wdata : req0_wdata;
                end else begin
                    q.push_back('{port: sp, data: sb_mem[ea], due: cyc + 4});
                end
                tb_last = sp;
            end
            @(negedge clk);
        end
        check("t6_drained", 64'(q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
